// File: rtl/arb_pkg.sv
// Shared types and constants for the one-hot round-robin arbiter.
package arb_pkg;

    // Arbiter FSM: either nobody owns the grant, or exactly one requester does.
    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_st_t;

    // The downstream 8-to-3 encoder only supports eight requesters.
    localparam int ARB_N            = 8;

    // Default cap on consecutive ownership while other requesters wait.
    localparam int ARB_MAX_HOLD_DEF = 16;

endpackage : arb_pkg

// File: rtl/rr_pick_1hot.sv
// Combinational circular priority picker: returns the first set bit of
// mask scanning upward from ptr, wrapping from N-1 to 0, as a one-hot vector.
module rr_pick_1hot
    import arb_pkg::*;
#(
    parameter int N  = ARB_N,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          any
);

    logic          found;
    logic [PW-1:0] idx;

    // Walk the candidates starting at ptr; the first hit wins, later hits are ignored.
    always_comb begin
        // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < N; off++) begin
            idx = PW'((int'(ptr) + off) % N);
            if (!found && mask[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // A winner exists exactly when at least one candidate is set.
    assign any = |mask;

endmodule : rr_pick_1hot

// File: rtl/rr_arbiter_1hot_8.sv
// Round-robin arbiter for level-sensitive requesters with grant locking and a
// bounded hold time. The registered grant is always zero or one-hot so the
// downstream one-hot-to-binary encoder never sees an illegal code.
module rr_arbiter_1hot_8
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         gnt_valid,
    output logic         preempt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    // Saturation value of the hold counter; reaching it with others waiting forces a handover.
    localparam logic [HW-1:0] HCNT_MAX = HW'(MAX_HOLD - 1);

    arb_st_t       st;
    logic [PW-1:0] ptr;
    logic [PW-1:0] own;
    logic [HW-1:0] hcnt;

    logic [N-1:0]  own_mask;
    logic [N-1:0]  cand;
    logic [N-1:0]  win;
    logic          win_any;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] win_nxt;
    logic          own_req;
    logic          hold_full;

    // Binary index of a one-hot vector; only ever applied to the picker output.
    function automatic logic [PW-1:0] onehot_to_idx(input logic [N-1:0] v);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                r = r | PW'(i);
            end
        end
        return r;
    endfunction

    assign own_mask = N'(1) << own;
    assign own_req  = req[own];
    assign hold_full = (hcnt == HCNT_MAX);

    // In OWN the current owner is masked out so a release or preempt always hands over to someone else.
    always_comb begin
        cand = req;
        if (st == OWN) begin
            cand = req & ~own_mask;
        end
    end

    rr_pick_1hot #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .mask (cand),
        .ptr  (ptr),
        .win  (win),
        .any  (win_any)
    );

    assign win_idx = onehot_to_idx(win);
    assign win_nxt = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);

    // FSM, round-robin pointer, hold counter and registered outputs in one clocked process.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: only control state and outputs are reset; all of it is small flop state, there is no memory here.
        if (reset) begin
            st        <= IDLE;
            ptr       <= '0;
            own       <= '0;
            hcnt      <= '0;
            grant     <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            preempt <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (win_any) begin
                        st        <= OWN;
                        own       <= win_idx;
                        ptr       <= win_nxt;
                        hcnt      <= '0;
                        grant     <= win;
                        gnt_valid <= 1'b1;
                    end else begin
                        grant     <= '0;
                        gnt_valid <= 1'b0;
                    end
                end

                OWN: begin
                    if (!own_req) begin
                        // Owner released: hand over back-to-back, or go idle if nobody else wants it.
                        if (win_any) begin
                            own       <= win_idx;
                            ptr       <= win_nxt;
                            hcnt      <= '0;
                            grant     <= win;
                            gnt_valid <= 1'b1;
                        end else begin
                            st        <= IDLE;
                            hcnt      <= '0;
                            grant     <= '0;
                            gnt_valid <= 1'b0;
                        end
                    end else if (hold_full && win_any) begin
                        // Owner overstayed while others wait: force the handover and flag it.
                        own       <= win_idx;
                        ptr       <= win_nxt;
                        hcnt      <= '0;
                        grant     <= win;
                        gnt_valid <= 1'b1;
                        preempt   <= 1'b1;
                    end else if (!hold_full) begin
                        // Owner keeps the grant; count toward the cap, saturating at HCNT_MAX.
                        hcnt <= hcnt + HW'(1);
                    end
                end

                default: begin
                    st        <= IDLE;
                    grant     <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : rr_arbiter_1hot_8

// File: tb/tb_rr_arbiter_1hot_8.sv
// Directed testbench for rr_arbiter_1hot_8 with hand-computed expected values.
module tb_rr_arbiter_1hot_8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic       gnt_valid;
    logic       preempt;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_g;
    logic [7:0] prev_g;

    rr_arbiter_1hot_8 #(
        .N        (8),
        .MAX_HOLD (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Grant, its valid flag and the preempt pulse checked together.
    task automatic check_out(input string tag, input logic [7:0] g, input logic p);
        check({tag, "_grant"}, grant, g);
        check({tag, "_valid"}, {7'b0, gnt_valid}, {7'b0, |g});
        check({tag, "_preempt"}, {7'b0, preempt}, {7'b0, p});
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        check_out("reset", 8'h00, 1'b0);
        tick();
        tick();
        check_out("reset_held", 8'h00, 1'b0);
        reset = 1'b0;

        // Basic grant then back-to-back release
        req = 8'h05;
        tick();
        check_out("basic_first", 8'h01, 1'b0);
        req = 8'h04;
        tick();
        check_out("basic_handover", 8'h04, 1'b0);
        req = 8'h00;
        tick();
        check_out("basic_idle", 8'h00, 1'b0);

        // Fairness: all request, each owner drops for two cycles after its grant
        sync_reset();
        req = 8'hFF;
        tick();
        prev_g = 8'h00;
        for (int i = 0; i < 17; i++) begin
            exp_g = 8'(1 << (i % 8));
            check_out("fair", exp_g, 1'b0);
            check("fair_1hot", grant & (grant - 8'h01), 8'h00);
            req = 8'hFF & ~exp_g & ~prev_g;
            prev_g = exp_g;
            tick();
        end
        req = 8'h00;
        tick();
        check_out("fair_idle", 8'h00, 1'b0);

        // Timeout: 0 and 7 both hold, ownership alternates every 16 cycles
        sync_reset();
        req = 8'h81;
        tick();
        for (int c = 0; c < 16; c++) begin
            check_out("tmo_own0", 8'h01, 1'b0);
            if (c < 15) tick();
        end
        tick();
        check_out("tmo_pre7", 8'h80, 1'b1);
        for (int c = 1; c < 16; c++) begin
            tick();
            check_out("tmo_own7", 8'h80, 1'b0);
        end
        tick();
        check_out("tmo_pre0", 8'h01, 1'b1);

        // Lone holder keeps the grant indefinitely; hold counter saturates
        sync_reset();
        req = 8'h10;
        tick();
        for (int c = 0; c < 40; c++) begin
            check_out("lone", 8'h10, 1'b0);
            tick();
        end
        check("lone_hcnt", 8'(dut.hcnt), 8'd15);
        // Saturated counter: a newcomer preempts on the very next edge (scan 5,6,7,0)
        req = 8'h11;
        tick();
        check_out("lone_newcomer", 8'h01, 1'b1);

        // Pointer wrap: owner 0 releases to 7, then the pointer wraps to 0
        req = 8'h80;
        tick();
        check_out("wrap_own7", 8'h80, 1'b0);
        req = 8'h00;
        tick();
        check_out("wrap_idle", 8'h00, 1'b0);
        req = 8'h03;
        tick();
        check_out("wrap_next", 8'h01, 1'b0);

        // Asynchronous reset mid-grant
        sync_reset();
        req = 8'h20;
        tick();
        check_out("areset_own5", 8'h20, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_out("areset_cleared", 8'h00, 1'b0);
        req = 8'h22;
        #1;
        reset = 1'b0;
        tick();
        check_out("areset_first", 8'h02, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rr_arbiter_1hot_8
